// File: rtl/alu_issue_writeback_if.sv
// Bundle between the issue/writeback shell and its neighbours: instruction
// handshake, register-file read/write ports, and the ALU operand/result buses.
interface alu_issue_writeback_if;
  // Handshake: an instruction moves when IN_VALID & IN_READY are both high at a
  // rising edge; IN_VALID may rise at any time, IN_READY drops while stalled.
  logic [31:0] INSTR;
  logic        IN_VALID;
  logic        IN_READY;
  logic        STALL;
  logic [2:0]  RA_N;
  logic [2:0]  RA_M;
  logic [31:0] RD_N;
  logic [31:0] RD_M;
  logic [3:0]  OP_CODE;
  logic [31:0] R1;
  logic [31:0] R2;
  logic        S;
  logic [4:0]  n;
  logic [15:0] i;
  logic [3:0]  COND;
  logic [3:0]  FLAGS_OUT;
  logic [31:0] ALU_OUT;
  logic [3:0]  ALU_FLAGS;
  logic        WE;
  logic [2:0]  WA;
  logic [31:0] WD;

  modport master (
    output INSTR, IN_VALID, STALL, RD_N, RD_M, ALU_OUT, ALU_FLAGS,
    input  IN_READY, RA_N, RA_M, OP_CODE, R1, R2, S, n, i, COND, FLAGS_OUT,
           WE, WA, WD
  );

  modport slave (
    input  INSTR, IN_VALID, STALL, RD_N, RD_M, ALU_OUT, ALU_FLAGS,
    output IN_READY, RA_N, RA_M, OP_CODE, R1, R2, S, n, i, COND, FLAGS_OUT,
           WE, WA, WD
  );
endinterface

// File: rtl/alu_issue_writeback.sv
// Decode/operand-forward (X) and condition/flags/writeback (W) stages wrapped
// around an external combinational ALU.
module alu_issue_writeback #(
    parameter int         NREG      = 8,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input logic            clk,
    input logic            rst_n,
    alu_issue_writeback_if.slave bus
);

    localparam int IDX_W = $clog2(NREG);

    // Decode of the incoming word
    logic [3:0]       d_cond;
    logic [3:0]       d_op;
    logic             d_s;
    logic             d_imm;
    logic [IDX_W-1:0] d_rd;
    logic [IDX_W-1:0] d_rn;
    logic [IDX_W-1:0] d_rm;
    logic [4:0]       d_n;
    logic [15:0]      d_i;
    logic [31:0]      d_r1;
    logic [31:0]      d_r2;

    // X stage
    logic             x_valid;
    logic             x_pass;
    logic [IDX_W-1:0] x_rd;
    logic [3:0]       x_op;
    logic [31:0]      x_r1;
    logic [31:0]      x_r2;
    logic             x_s;
    logic [4:0]       x_n;
    logic [15:0]      x_i;
    logic [3:0]       x_cond;

    // W stage and architectural flags {N,Z,C,V}
    logic             w_valid;
    logic [2:0]       w_addr;
    logic [31:0]      w_data;
    logic [3:0]       flags;

    logic             accept;
    logic             x_live;

    assign accept = bus.IN_VALID & rst_n & ~bus.STALL;
    assign x_live = x_valid & x_pass;

    always_comb begin
        d_cond = bus.INSTR[31:28];
        d_op   = bus.INSTR[27:24];
        d_s    = bus.INSTR[23];
        d_imm  = bus.INSTR[22];
        d_rd   = bus.INSTR[21:19];
        d_rn   = bus.INSTR[18:16];
        d_rm   = '0;
        d_n    = '0;
        d_i    = '0;
        if (d_imm) begin
            d_i = bus.INSTR[15:0];
        end else begin
            d_rm = bus.INSTR[15:13];
            d_n  = bus.INSTR[12:8];
        end
    end

    // Youngest producer wins: an in-flight X result shadows the W result.
    always_comb begin
        d_r1 = bus.RD_N;
        if (x_live && (x_rd == d_rn)) begin
            d_r1 = bus.ALU_OUT;
        end else if (w_valid && (w_addr == d_rn)) begin
            d_r1 = w_data;
        end

        d_r2 = bus.RD_M;
        if (d_imm) begin
            d_r2 = '0;
        end else if (x_live && (x_rd == d_rm)) begin
            d_r2 = bus.ALU_OUT;
        end else if (w_valid && (w_addr == d_rm)) begin
            d_r2 = w_data;
        end
    end

    always_comb begin
        x_pass = 1'b0;
        case (x_cond)
            4'd0:    x_pass = 1'b1;
            4'd1:    x_pass = flags[2];
            4'd2:    x_pass = ~flags[2];
            4'd3:    x_pass = flags[1];
            4'd4:    x_pass = ~flags[1];
            4'd5:    x_pass = flags[3];
            4'd6:    x_pass = ~flags[3];
            4'd7:    x_pass = flags[0];
            4'd8:    x_pass = ~flags[0];
            default: x_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid <= 1'b0;
            x_rd    <= '0;
            x_op    <= '0;
            x_r1    <= '0;
            x_r2    <= '0;
            x_s     <= 1'b0;
            x_n     <= '0;
            x_i     <= '0;
            x_cond  <= '0;
        end else if (accept) begin
            x_valid <= 1'b1;
            x_rd    <= d_rd;
            x_op    <= d_op;
            x_r1    <= d_r1;
            x_r2    <= d_r2;
            x_s     <= d_s;
            x_n     <= d_n;
            x_i     <= d_i;
            x_cond  <= d_cond;
        end else if (!bus.STALL) begin
            x_valid <= 1'b0;
        end
    end

    // Flags update on the X->W edge so the very next instruction's condition sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
            flags   <= RST_FLAGS;
        end else if (!bus.STALL) begin
            w_valid <= x_live;
            w_addr  <= x_rd;
            w_data  <= bus.ALU_OUT;
            if (x_live && x_s) begin
                flags <= bus.ALU_FLAGS;
            end
        end
    end

    assign bus.IN_READY  = rst_n & ~bus.STALL;
    assign bus.RA_N      = d_rn;
    assign bus.RA_M      = d_rm;
    assign bus.OP_CODE   = x_op;
    assign bus.R1        = x_r1;
    assign bus.R2        = x_r2;
    assign bus.S         = x_s;
    assign bus.n         = x_n;
    assign bus.i         = x_i;
    assign bus.COND      = x_cond;
    assign bus.FLAGS_OUT = flags;
    assign bus.WE        = w_valid & ~bus.STALL;
    assign bus.WA        = w_addr;
    assign bus.WD        = w_data;

endmodule
